mux_scan_sequencer: RTL
=======================

# mux_scan_sequencer

Scan controller for the 8:1 channel multiplexer: it drives the 3-bit select in a fixed 0→7 sequence and samples the multiplexer's 1-bit output at each channel. It assembles the eight samples into a byte and presents that byte downstream over a valid/ready handshake. The block sits directly upstream of the multiplexer's select input and directly downstream of its data output, with the multiplexer purely combinational in between. It supports single-shot and continuous scanning, with a programmable settle delay per channel.

## Interface
- SETTLE, default 0 — extra wait cycles per channel after `sel` changes, before sampling; legal range 0–15.
- clk  in  1  — single clock; all state updates on the rising edge.
- rst  in  1  — synchronous, active-high reset.
- start  in  1  — request a scan; accepted only in IDLE.
- cont  in  1  — continuous mode; sampled on each handshake completion.
- mux_out  in  1  — combinational output of the 8:1 multiplexer.
- sel  out  3  — channel select driven to the multiplexer; registered.
- busy  out  1  — high in SETTLE, SAMPLE and HOLD.
- word  out  8  — assembled scan result; `word[k]` holds channel k.
- word_valid  out  1  — result available; high only in HOLD.
- word_ready  in  1  — downstream accepts `word`.

## Operation
- States:
  - IDLE → SETTLE (when SETTLE > 0) or SAMPLE, on `start`.
  - SETTLE → SAMPLE when the settle counter reaches 0.
  - SAMPLE → SETTLE/SAMPLE for the next channel, or → HOLD after channel 7.
  - HOLD → IDLE or a new scan, on `word_ready`.
- Start acceptance (IDLE with `start` = 1):
  - Channel index `idx` ← 0; `sel` ← 0.
  - Settle counter ← SETTLE.
  - `word` ← 0 (the previous result is discarded only when a new scan starts).
- SETTLE: counter decrements once per cycle; `sel` holds `idx`.
- SAMPLE:
  - `word[idx]` ← `mux_out`.
  - If `idx` < 7: `idx` increments, `sel` follows, counter reloads SETTLE.
  - If `idx` = 7: go to HOLD.
- HOLD:
  - `word` and `sel` (= 7) are held stable; `word_valid` = 1.
  - Stays in HOLD until `word_ready` = 1.
  - On the handshake, with `cont` = 1: start a new scan exactly as on start acceptance.
  - On the handshake, with `cont` = 0: go to IDLE with `sel` ← 0.
- `start` outside IDLE is ignored; it is not queued.
- Changes to `cont` outside HOLD have no effect until the next handshake.
- `idx` wraps 7→0 only through a restart; it never increments past 7.

## Timing
- Reset values: state IDLE, `sel` = 0, `word` = 0, `word_valid` = 0, `busy` = 0, idx = 0, settle counter = 0.
- Reset asserted mid-scan or in HOLD: all of the above on the next edge; any partial word is lost.
- `sel` is registered. Sampling of `mux_out` always occurs ≥ 1 full cycle after the `sel` update; the multiplexer path is a single-cycle combinational path.
- Latency from the start-accept edge to the first cycle with `word_valid` high: 8·(SETTLE+1) cycles.
  - SETTLE = 0: 8 cycles.
  - SETTLE = 2: 24 cycles.
- Continuous mode with `word_ready` held high: one word every 8·(SETTLE+1)+1 cycles.
- `word_valid` deasserts on the edge after the handshake.
- `busy` = 1 from the edge after `start` acceptance until IDLE is re-entered.

## Structure
- Shared package `mux_scan_pkg` holds:
  - State enum: IDLE, SETTLE, SAMPLE, HOLD.
  - Constants CH_COUNT = 8, SEL_W = 3, SETTLE_W = 4.
- One natural sub-module, `scan_settle_counter`: a loadable down-counter with a `zero` flag, parameterised by SETTLE_W.
- The 8:1 multiplexer itself is instantiated outside this block; in the testbench, the two are wired together.

## Test plan
- SETTLE = 0, multiplexer inputs static 8'hA5, `start` pulsed, `word_ready` = 1 → `sel` steps 0..7 on consecutive cycles; `word_valid` high 8 cycles after accept; `word` = 8'hA5; returns to IDLE.
- SETTLE = 2, inputs 8'h3C → each `sel` value held 3 cycles; `word_valid` at cycle 24; `word` = 8'h3C.
- Backpressure: `word_ready` low for 10 cycles in HOLD → `word_valid` held, `word`/`sel` stable; handshake on cycle 11 → `word_valid` drops next edge.
- Continuous mode: `cont` = 1, inputs change 8'h0F→8'hF0 between scans → two words, 8'h0F then 8'hF0; `sel` wraps 7→0 immediately after the first handshake.
- `start` pulsed during SAMPLE → ignored; exactly one word produced.
- `rst` asserted while `idx` = 4 → next cycle: IDLE, `sel` = 0, `word` = 0, `busy` = 0, `word_valid` = 0; a fresh `start` then produces a correct full word.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 8:1 multiplexer scan sequencer.
package mux_scan_pkg;

    localparam int unsigned CH_COUNT = 8;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned SETTLE_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StHold
    } scan_state_e;

endpackage

// File: rtl/scan_settle_counter.sv
// Loadable down-counter timing the per-channel settle window after a select change.
module scan_settle_counter
    import mux_scan_pkg::*;
#(
    parameter int unsigned Width = SETTLE_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             last_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    // Decrementing from one reaches zero on this edge, so settling ends now.
    assign last_o = (cnt_q == Width'(1));

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the multiplexer select through channels 0..7, samples each channel into a byte
// and offers the byte downstream over a valid/ready handshake.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                cont_i,
    input  logic                mux_out_i,
    output logic [SEL_W-1:0]    sel_o,
    output logic                busy_o,
    output logic [CH_COUNT-1:0] word_o,
    output logic                word_valid_o,
    input  logic                word_ready_i
);

    localparam logic [SEL_W-1:0]    LastCh     = SEL_W'(CH_COUNT - 1);
    localparam logic [SETTLE_W-1:0] SettleVal  = SETTLE_W'(SETTLE);
    localparam scan_state_e         FirstPhase = (SETTLE != 0) ? StSettle : StSample;

    scan_state_e         state_q, state_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [CH_COUNT-1:0] word_q, word_d;

    logic cnt_load, cnt_dec, cnt_zero, cnt_last;
    logic restart;

    scan_settle_counter #(
        .Width (SETTLE_W)
    ) u_settle_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (SettleVal),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero),
        .last_o     (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        word_d   = word_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        restart  = 1'b0;

        unique case (state_q)
            StIdle: begin
                restart = start_i;
            end
            StSettle: begin
                cnt_dec = 1'b1;
                if (cnt_zero || cnt_last) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                word_d[idx_q] = mux_out_i;
                if (idx_q == LastCh) begin
                    state_d = StHold;
                end else begin
                    idx_d    = idx_q + SEL_W'(1);
                    cnt_load = 1'b1;
                    state_d  = FirstPhase;
                end
            end
            StHold: begin
                if (word_ready_i) begin
                    if (cont_i) begin
                        restart = 1'b1;
                    end else begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Start accept and continuous restart share one path; the old word is dropped here.
        if (restart) begin
            idx_d    = '0;
            word_d   = '0;
            cnt_load = 1'b1;
            state_d  = FirstPhase;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

    assign sel_o        = idx_q;
    assign word_o       = word_q;
    assign word_valid_o = (state_q == StHold);
    assign busy_o       = (state_q != StIdle);

endmodule
